// File: rtl/fan_tach_meter.sv
// -----------------------------------------------------------------------------
// fan_tach_meter
//
// Fan tachometer front end. The open-drain tach pin is synchronised into the
// clk_i domain and debounced on clk_en_i sample ticks. The falling edges of the
// filtered level are counted over a fixed gate window of GATE_TICKS ticks. At
// every window end the saturated count is published on speed_o together with
// a one-cycle speed_valid_o strobe, in the same form as the ADC_value/dataValid
// pair used by the controller core. stall_o flags a fan that has produced no
// edge for STALL_WINDOWS consecutive windows.
//
// The first window after reset is a priming window: it is measured but not
// published, because it may have started part-way through a tach period.
//
// Ports
//   clk_i          in   1               system clock
//   rst_i          in   1               asynchronous active-high reset
//   clk_en_i       in   1               sample tick, one clk_i cycle wide
//   tach_i         in   1               raw tach pin, asynchronous, idle high
//   speed_o        out  SPEED_BITWIDTH  falling-edge count of last window
//   speed_valid_o  out  1               strobe, high when speed_o updates
//   stall_o        out  1               last STALL_WINDOWS windows counted 0
// -----------------------------------------------------------------------------
module fan_tach_meter #(
  parameter logic [15:0] GATE_TICKS     = 16'd50000,
  parameter logic [3:0]  DEBOUNCE_TICKS = 4'd3,
  parameter logic [2:0]  STALL_WINDOWS  = 3'd4,
  parameter int          SPEED_BITWIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  input  logic                      tach_i,
  output logic [SPEED_BITWIDTH-1:0] speed_o,
  output logic                      speed_valid_o,
  output logic                      stall_o
);

  // FSM encoding
  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [SPEED_BITWIDTH-1:0] CNT_ZERO = {SPEED_BITWIDTH{1'b0}};
  localparam logic [SPEED_BITWIDTH-1:0] CNT_MAX  = {SPEED_BITWIDTH{1'b1}};
  localparam logic [SPEED_BITWIDTH-1:0] CNT_ONE  =
    {{(SPEED_BITWIDTH-1){1'b0}}, 1'b1};

  // Saturating increment: holds at all-ones so the count can never wrap.
  function automatic logic [SPEED_BITWIDTH-1:0] sat_inc(
    input logic [SPEED_BITWIDTH-1:0] val,
    input logic                      inc
  );
    logic [SPEED_BITWIDTH-1:0] res;
    if (inc && (val != CNT_MAX)) begin
      res = val + CNT_ONE;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Synchroniser
  logic sync1_q;
  logic sync2_q;

  // Debounce
  logic       filt_q;
  logic       filt_d;
  logic [3:0] deb_cnt_q;
  logic [3:0] deb_cnt_d;
  logic       edge_s;

  // Gate window
  logic [15:0] gate_q;
  logic [15:0] gate_d;
  logic        win_end_s;

  // Edge counter
  logic [SPEED_BITWIDTH-1:0] cnt_q;
  logic [SPEED_BITWIDTH-1:0] cnt_d;
  logic [SPEED_BITWIDTH-1:0] closing_cnt_s;

  // FSM
  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       publish_s;

  // Published outputs and stall tracking
  logic [SPEED_BITWIDTH-1:0] speed_q;
  logic [SPEED_BITWIDTH-1:0] speed_d;
  logic                      valid_q;
  logic                      valid_d;
  logic [2:0]                zcnt_q;
  logic [2:0]                zcnt_d;
  logic                      stall_q;
  logic                      stall_d;

  // Two-flop synchroniser, runs every clk_i cycle; resets to the idle level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= tach_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the filtered level flips only after DEBOUNCE_TICKS consecutive
  // disagreeing sample ticks; a single agreeing tick restarts the count.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    if (clk_en_i) begin
      if (sync2_q != filt_q) begin
        if (deb_cnt_q == (DEBOUNCE_TICKS - 4'd1)) begin
          filt_d    = ~filt_q;
          deb_cnt_d = 4'd0;
        end else begin
          deb_cnt_d = deb_cnt_q + 4'd1;
        end
      end else begin
        deb_cnt_d = 4'd0;
      end
    end else begin
      filt_d    = filt_q;
      deb_cnt_d = deb_cnt_q;
    end
  end

  // The edge is flagged in the cycle the filter decides to fall, so an edge
  // coinciding with the window-end tick can still be folded into that window.
  assign edge_s = filt_q & ~filt_d;

  // Gate counter: 0 .. GATE_TICKS-1 on sample ticks, then wraps.
  always_comb begin
    win_end_s = clk_en_i && (gate_q == (GATE_TICKS - 16'd1));
    gate_d    = gate_q;
    if (win_end_s) begin
      gate_d = 16'd0;
    end else if (clk_en_i) begin
      gate_d = gate_q + 16'd1;
    end else begin
      gate_d = gate_q;
    end
  end

  // Edge counter: the closing value includes an edge in the window-end cycle.
  always_comb begin
    closing_cnt_s = sat_inc(cnt_q, edge_s);
    if (win_end_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = closing_cnt_s;
    end
  end

  // FSM: the priming window is measured but never published.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRIME: begin
        if (win_end_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_PRIME;
      end
    endcase
  end

  assign publish_s = win_end_s && (state_q == ST_RUN);

  // Publish path: speed, strobe, zero-window counter and stall flag all
  // change together at a publishing window end.
  always_comb begin
    speed_d = speed_q;
    valid_d = publish_s;
    zcnt_d  = zcnt_q;
    stall_d = stall_q;
    if (publish_s) begin
      speed_d = closing_cnt_s;
      if (closing_cnt_s == CNT_ZERO) begin
        if (zcnt_q == STALL_WINDOWS) begin
          zcnt_d = zcnt_q;
        end else begin
          zcnt_d = zcnt_q + 3'd1;
        end
      end else begin
        zcnt_d = 3'd0;
      end
      stall_d = (zcnt_d == STALL_WINDOWS);
    end else begin
      speed_d = speed_q;
      zcnt_d  = zcnt_q;
      stall_d = stall_q;
    end
  end

  // State registers for debounce, gate, counter and FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q    <= 1'b1;
      deb_cnt_q <= 4'd0;
      gate_q    <= 16'd0;
      cnt_q     <= CNT_ZERO;
      state_q   <= ST_PRIME;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      speed_q <= CNT_ZERO;
      valid_q <= 1'b0;
      zcnt_q  <= 3'd0;
      stall_q <= 1'b0;
    end else begin
      speed_q <= speed_d;
      valid_q <= valid_d;
      zcnt_q  <= zcnt_d;
      stall_q <= stall_d;
    end
  end

  assign speed_o       = speed_q;
  assign speed_valid_o = valid_q;
  assign stall_o       = stall_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// -----------------------------------------------------------------------------
// tb_fan_tach_meter
//
// Directed bench for fan_tach_meter. Instance A uses GATE_TICKS=100,
// DEBOUNCE_TICKS=3, STALL_WINDOWS=2; instance B uses DEBOUNCE_TICKS=1,
// GATE_TICKS=1000 for the saturation case. clk_en_i is high every 4th clk
// cycle. Each call of do_tick is one sample tick: tach is set at the start of
// the tick and outputs are sampled 1 ns after the enabled clock edge.
// -----------------------------------------------------------------------------
module tb_fan_tach_meter;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic       clk_en;
  logic       tach_a;
  logic       tach_b;
  logic [7:0] speed_a;
  logic [7:0] speed_b;
  logic       valid_a;
  logic       valid_b;
  logic       stall_a;
  logic       stall_b;

  logic       b_run;
  int         n_checks;
  int         n_fail;
  int         strobe_cycles_a;

  fan_tach_meter #(
    .GATE_TICKS     (16'd100),
    .DEBOUNCE_TICKS (4'd3),
    .STALL_WINDOWS  (3'd2),
    .SPEED_BITWIDTH (8)
  ) dut_a (
    .clk_i         (clk),
    .rst_i         (rst_a),
    .clk_en_i      (clk_en),
    .tach_i        (tach_a),
    .speed_o       (speed_a),
    .speed_valid_o (valid_a),
    .stall_o       (stall_a)
  );

  fan_tach_meter #(
    .GATE_TICKS     (16'd1000),
    .DEBOUNCE_TICKS (4'd1),
    .STALL_WINDOWS  (3'd2),
    .SPEED_BITWIDTH (8)
  ) dut_b (
    .clk_i         (clk),
    .rst_i         (rst_b),
    .clk_en_i      (clk_en),
    .tach_i        (tach_b),
    .speed_o       (speed_b),
    .speed_valid_o (valid_b),
    .stall_o       (stall_b)
  );

  // 10 MHz clock
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Counts every clk cycle in which A's strobe is high; with one-cycle
  // strobes this equals the number of publications.
  initial begin
    strobe_cycles_a = 0;
    forever begin
      @(posedge clk);
      #1;
      if (valid_a === 1'b1) strobe_cycles_a = strobe_cycles_a + 1;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One sample tick: tach set at the first negedge, enable on the fourth.
  task automatic do_tick(input logic t);
    @(negedge clk);
    tach_a = t;
    clk_en = 1'b0;
    if (b_run) tach_b = ~tach_b;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Tick i (0-based) is low when (i+phase) % period < low_len.
  task automatic run_wave(input int n, input int period, input int low_len,
                          input int phase);
    for (int i = 0; i < n; i++) begin
      do_tick(((i + phase) % period) < low_len ? 1'b0 : 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    b_run    = 1'b0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;
    clk_en   = 1'b0;
    tach_a   = 1'b1;
    tach_b   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_speed_a", speed_a, 0);
    check_eq("rst_valid_a", valid_a, 0);
    check_eq("rst_stall_a", stall_a, 0);
    check_eq("rst_speed_b", speed_b, 0);
    check_eq("rst_valid_b", valid_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Prime window: no strobe at tick 100
    run_wave(100, 1, 0, 0);
    check_eq("prime_no_valid", valid_a, 0);
    check_eq("prime_no_strobe", strobe_cycles_a, 0);
    // First strobe at tick 200
    run_wave(100, 1, 0, 0);
    check_eq("t200_valid", valid_a, 1);
    check_eq("t200_speed", speed_a, 0);
    check_eq("t200_stall", stall_a, 0);
    // Second zero window raises stall
    run_wave(100, 1, 0, 0);
    check_eq("t300_valid", valid_a, 1);
    check_eq("t300_speed", speed_a, 0);
    check_eq("t300_stall", stall_a, 1);
    check_eq("t300_strobes", strobe_cycles_a, 2);

    // Steady 10-tick square wave, low first
    run_wave(100, 10, 5, 0);
    check_eq("sq1_speed", speed_a, 10);
    check_eq("sq1_stall", stall_a, 0);
    run_wave(100, 10, 5, 0);
    check_eq("sq2_valid", valid_a, 1);
    check_eq("sq2_speed", speed_a, 10);
    check_eq("sq2_strobe_width", strobe_cycles_a, 4);

    // Glitch rejection: 2-tick pulses rejected, 3-tick pulses counted
    run_wave(100, 10, 2, 0);
    check_eq("glitch2_speed", speed_a, 0);
    check_eq("glitch2_stall", stall_a, 0);
    run_wave(100, 10, 3, 0);
    check_eq("glitch3_speed", speed_a, 10);

    // Boundary: one edge mid-window, one exactly at the window-end tick
    run_wave(10, 1, 0, 0);
    run_wave(3, 1, 1, 0);
    run_wave(84, 1, 0, 0);
    run_wave(3, 1, 1, 0);
    check_eq("boundary_valid", valid_a, 1);
    check_eq("boundary_speed", speed_a, 2);
    run_wave(100, 1, 1, 0);
    check_eq("after_boundary_speed", speed_a, 0);

    // Square wave high first, then reset mid-window
    run_wave(100, 10, 5, 5);
    check_eq("t1000_speed", speed_a, 10);
    run_wave(50, 10, 5, 5);
    check_eq("pre_reset_strobes", strobe_cycles_a, 9);
    #2;
    rst_a  = 1'b1;
    clk_en = 1'b0;
    #1;
    check_eq("async_rst_speed", speed_a, 0);
    check_eq("async_rst_valid", valid_a, 0);
    check_eq("async_rst_stall", stall_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    run_wave(100, 10, 5, 0);
    check_eq("rst_prime_no_valid", valid_a, 0);
    check_eq("rst_prime_strobes", strobe_cycles_a, 9);
    run_wave(100, 10, 5, 0);
    check_eq("rst_first_valid", valid_a, 1);
    check_eq("rst_first_speed", speed_a, 10);
    check_eq("rst_first_stall", stall_a, 0);

    // Saturation on instance B: toggle every tick, 500 edges per window
    #2;
    rst_b  = 1'b1;
    clk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    b_run = 1'b1;
    run_wave(1000, 1, 0, 0);
    check_eq("sat_prime_no_valid", valid_b, 0);
    check_eq("sat_prime_speed", speed_b, 0);
    run_wave(1000, 1, 0, 0);
    check_eq("sat_valid", valid_b, 1);
    check_eq("sat_speed", speed_b, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
